// File: rtl/parallel_pe.sv
// Parallel signed multiply-accumulate PE: LANES multipliers, a registered adder tree,
// then an accumulator with saturate/truncate and ReLU output shaping.
module parallel_pe_lane #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic [2*DW-1:0] p_o
);
    logic [2*DW-1:0] p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    p_q <= '0;
        else if (en_i) p_q <= $signed(a_i) * $signed(b_i);
    end

    assign p_o = p_q;
endmodule

module parallel_pe #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int ACC_W = 40,
    parameter int OW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LANES*DW-1:0] neuron,
    input  logic [LANES*DW-1:0] weight,
    input  logic [1:0]          ctl,
    input  logic [1:0]          mode,
    input  logic                vld_i,
    output logic [OW-1:0]       result,
    output logic                sat_o,
    output logic                vld_o
);
    localparam int L  = $clog2(LANES);
    localparam int TW = 2*DW + L;

    // Bit offset of tree level lv (1..L) in the flattened level register; each
    // level grows by one bit so no level can overflow.
    function automatic int lvl_off(input int lv);
        int o;
        o = 0;
        for (int k = 1; k < lv; k++) o += (LANES >> k) * (2*DW + k);
        return o;
    endfunction

    localparam int TREE_BITS = (L == 0) ? 1 : lvl_off(L + 1);

    logic [L:0]                 vld_pipe;
    logic [L:0][1:0]            ctl_pipe;
    logic [L:0][1:0]            mode_pipe;
    logic [LANES-1:0][2*DW-1:0] prod;
    logic [TREE_BITS-1:0]       lvl_q;
    logic signed [TW-1:0]       tree_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            ctl_pipe  <= '0;
            mode_pipe <= '0;
        end else begin
            vld_pipe[0]  <= vld_i;
            ctl_pipe[0]  <= ctl;
            mode_pipe[0] <= mode;
            for (int k = 1; k <= L; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                ctl_pipe[k]  <= ctl_pipe[k-1];
                mode_pipe[k] <= mode_pipe[k-1];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parallel_pe_lane #(.DW(DW)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (vld_i),
            .a_i   (neuron[i*DW +: DW]),
            .b_i   (weight[i*DW +: DW]),
            .p_o   (prod[i])
        );
    end

    if (L == 0) begin : g_flat
        assign tree_sum = prod[0];
    end else begin : g_tree
        for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
            localparam int N  = LANES >> lv;
            localparam int W  = 2*DW + lv;
            localparam int O  = lvl_off(lv);
            localparam int PO = lvl_off(lv - 1);
            for (genvar n = 0; n < N; n++) begin : g_node
                logic [W-2:0] a_w, b_w;
                if (lv == 1) begin : g_src
                    assign a_w = prod[2*n];
                    assign b_w = prod[2*n+1];
                end else begin : g_src
                    assign a_w = lvl_q[PO + (2*n)*(W-1)   +: W-1];
                    assign b_w = lvl_q[PO + (2*n+1)*(W-1) +: W-1];
                end
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        lvl_q[O + n*W +: W] <= '0;
                    else if (vld_pipe[lv-1])
                        lvl_q[O + n*W +: W] <= {a_w[W-2], a_w} + {b_w[W-2], b_w};
                end
            end
        end
        assign tree_sum = lvl_q[lvl_off(L) +: TW];
    end

    logic signed [ACC_W-1:0] sum_ext, acc_q, acc_d;
    logic                    fits, sat_d, vld_d, sat_q, vld_q;
    logic [OW-1:0]           clip, res_d, result_q;

    assign sum_ext = ACC_W'(tree_sum);

    always_comb begin
        acc_d = acc_q;
        if (vld_pipe[L]) acc_d = ctl_pipe[L][0] ? sum_ext : acc_q + sum_ext;
    end

    // Fits in signed OW when every bit from the OW sign bit up agrees.
    always_comb begin
        fits = (&acc_d[ACC_W-1:OW-1]) | ~(|acc_d[ACC_W-1:OW-1]);
        clip = acc_d[OW-1:0];
        if (!fits && mode_pipe[L][0])
            clip = acc_d[ACC_W-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        res_d = (mode_pipe[L][1] && clip[OW-1]) ? '0 : clip;
        sat_d = ~fits;
        vld_d = vld_pipe[L] & ctl_pipe[L][1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            acc_q <= acc_d;
            vld_q <= vld_d;
            if (vld_d) begin
                result_q <= res_d;
                sat_q    <= sat_d;
            end
        end
    end

    assign result = result_q;
    assign sat_o  = sat_q;
    assign vld_o  = vld_q;
endmodule

// File: tb/tb_parallel_pe.sv
// Scoreboard bench for parallel_pe (LANES=4, DW=16, ACC_W=40, OW=32): stimulus pushes
// expected result/sat/arrival edge, a negedge monitor pops and compares on vld_o.
module tb_parallel_pe;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int ACC_W = 40;
    localparam int OW    = 32;
    localparam int LAT   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [LANES*DW-1:0] neuron = '0;
    logic [LANES*DW-1:0] weight = '0;
    logic [1:0]          ctl = '0;
    logic [1:0]          mode = '0;
    logic                vld_i = 1'b0;
    logic [OW-1:0]       result;
    logic                sat_o;
    logic                vld_o;

    parallel_pe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .OW(OW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .mode   (mode),
        .vld_i  (vld_i),
        .result (result),
        .sat_o  (sat_o),
        .vld_o  (vld_o)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic        sat;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (vld_o) begin
            if (sb.size() == 0) begin
                check("unexpected_vld", {31'b0, vld_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("sat_o", {31'b0, sat_o}, {31'b0, e.sat});
                check("latency", edge_cnt, e.due);
            end
        end
    end

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic beat(input logic [63:0] n, input logic [63:0] w, input logic [1:0] c,
                        input logic [1:0] m, input logic [31:0] er, input logic es);
        neuron = n;
        weight = w;
        ctl    = c;
        mode   = m;
        vld_i  = 1'b1;
        if (c[1]) sb.push_back('{res: er, sat: es, due: edge_cnt + LAT});
        @(posedge clk);
        #1;
        vld_i = 1'b0;
    endtask

    // Garbage on data/ctl while invalid must be ignored.
    task automatic bubble();
        vld_i  = 1'b0;
        neuron = '1;
        weight = '1;
        ctl    = 2'b11;
        mode   = 2'b11;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results still pending", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [63:0] va, vb, v1, vn3, vw7, vmax, vmin, v256;

    initial begin
        va   = pk(1, 2, 3, 4);
        vb   = pk(5, 6, 7, 8);
        v1   = pk(1, 1, 1, 1);
        vn3  = pk(-3, -3, -3, -3);
        vw7  = pk(7, 7, 7, 7);
        vmax = pk(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
        vmin = pk(-32768, -32768, -32768, -32768);
        v256 = pk(256, 256, 256, 256);

        repeat (2) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_sat", {31'b0, sat_o}, 32'd0);
        check("rst_vld", {31'b0, vld_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bubble();

        beat(va, vb, 2'b11, 2'b00, 32'd70, 1'b0);
        drain();

        for (int b = 0; b < 32; b++)
            beat(v256, v256, {b == 31, b == 0}, 2'b00, 32'h0080_0000, 1'b0);
        drain();
        for (int b = 0; b < 32; b++) begin
            beat(v256, v256, {b == 31, b == 0}, 2'b00, 32'h0080_0000, 1'b0);
            if (b != 31) bubble();
        end
        drain();

        beat(vn3, vw7, 2'b11, 2'b00, 32'hFFFF_FFAC, 1'b0);
        beat(vn3, vw7, 2'b11, 2'b10, 32'd0, 1'b0);
        drain();

        beat(vmax, vmax, 2'b11, 2'b01, 32'h7FFF_FFFF, 1'b1);
        beat(vmax, vmax, 2'b11, 2'b00, 32'hFFFC_0004, 1'b1);
        beat(vmax, vmax, 2'b11, 2'b11, 32'h7FFF_FFFF, 1'b1);
        beat(vmax, vmax, 2'b11, 2'b10, 32'd0, 1'b1);
        beat(vmin, vmax, 2'b11, 2'b01, 32'h8000_0000, 1'b1);
        beat(vmin, vmax, 2'b11, 2'b00, 32'h0002_0000, 1'b1);
        beat(vmin, vmax, 2'b11, 2'b11, 32'd0, 1'b1);
        drain();

        beat(va, vb, 2'b11, 2'b00, 32'd70, 1'b0);
        beat(vn3, vw7, 2'b11, 2'b00, 32'hFFFF_FFAC, 1'b0);
        drain();
        beat(va, vb, 2'b11, 2'b00, 32'd70, 1'b0);
        bubble();
        bubble();
        beat(v1, va, 2'b10, 2'b00, 32'd80, 1'b0);
        drain();

        for (int b = 0; b <= 10; b++)
            beat(v256, v256, {1'b0, b == 0}, 2'b00, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_result", result, 32'd0);
        check("midrst_sat", {31'b0, sat_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrst_vld", {31'b0, vld_o}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (6) bubble();
        beat(va, vb, 2'b10, 2'b00, 32'd70, 1'b0);
        drain();

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
